// File: rtl/led_arbiter.sv
// led_arbiter
//   Fixed-priority arbiter for the board RGB status LED. Three requesters
//   compete for the LED; the winner holds it for at least DWELL prescaled
//   ticks, shown steady or blinking in the colour captured at grant time.
//
//   Parameters
//     CLKDIV  SYSCLK cycles per tick (>= 1)
//     DWELL   minimum hold per grant, in ticks (>= 1)
//
//   Ports
//     SYSCLK                      system clock, rising edge
//     RESET                       asynchronous, active-high reset
//     REQ[2:0]                    request levels, bit 0 highest priority
//     COLOR0/1/2[2:0]             per-source colour {R,G,B}, sampled at grant
//     BLINK[2:0]                  per-source blink enable, sampled at grant
//     GRANT[2:0]                  one-hot owner, 0 when nobody owns the LED
//     BUSY                        high while holding or in the gap cycle
//     LED_RED/LED_GREEN/LED_BLUE  registered active-high LED drive
module led_arbiter #(
  parameter int unsigned CLKDIV = 5,
  parameter int unsigned DWELL  = 4
) (
  input  logic       SYSCLK,
  input  logic       RESET,
  input  logic [2:0] REQ,
  input  logic [2:0] COLOR0,
  input  logic [2:0] COLOR1,
  input  logic [2:0] COLOR2,
  input  logic [2:0] BLINK,
  output logic [2:0] GRANT,
  output logic       BUSY,
  output logic       LED_RED,
  output logic       LED_GREEN,
  output logic       LED_BLUE
);

  localparam int unsigned PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
  localparam logic [PW-1:0] CNT_MAX  = PW'(CLKDIV - 1);
  localparam logic [DW-1:0] DWELL_LD = DW'(DWELL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [2:0]    grant_n;
  logic          busy_n;
  logic [2:0]    led_q, led_n;
  logic [PW-1:0] cnt, cnt_n;
  logic [DW-1:0] dwell, dwell_n;
  logic          phase, phase_n;
  logic [2:0]    lat_color, lat_color_n;
  logic          lat_blink, lat_blink_n;

  logic [2:0]    win_oh;
  logic [2:0]    sel_color;
  logic          sel_blink;
  logic          tick;
  logic          owner_req;
  logic          higher_req;

  // Lowest set bit of REQ is the winner (two's-complement isolate).
  assign win_oh    = REQ & (~REQ + 3'd1);
  assign sel_color = ({3{win_oh[0]}} & COLOR0)
                   | ({3{win_oh[1]}} & COLOR1)
                   | ({3{win_oh[2]}} & COLOR2);
  assign sel_blink = |(win_oh & BLINK);

  assign tick       = (state == HOLD) && (cnt == CNT_MAX);
  assign owner_req  = |(REQ & GRANT);
  // GRANT-1 masks every index below the one-hot owner, i.e. higher priority.
  assign higher_req = |(REQ & (GRANT - 3'd1));

  always_comb begin
    state_n     = state;
    grant_n     = GRANT;
    led_n       = led_q;
    cnt_n       = cnt;
    dwell_n     = dwell;
    phase_n     = phase;
    lat_color_n = lat_color;
    lat_blink_n = lat_blink;

    unique case (state)
      IDLE, GAP: begin
        if (REQ != 3'b000) begin
          state_n     = HOLD;
          grant_n     = win_oh;
          lat_color_n = sel_color;
          lat_blink_n = sel_blink;
          dwell_n     = DWELL_LD;
          cnt_n       = '0;
          phase_n     = 1'b1;
          led_n       = sel_color;
        end else begin
          state_n = IDLE;
          grant_n = '0;
          led_n   = '0;
        end
      end

      HOLD: begin
        if ((dwell == '0) && (!owner_req || higher_req)) begin
          state_n = GAP;
          grant_n = '0;
          led_n   = '0;
        end else begin
          cnt_n = tick ? '0 : cnt + 1'b1;
          if (tick) begin
            phase_n = ~phase;
            if (dwell != '0) begin
              dwell_n = dwell - 1'b1;
            end
          end
          // LED follows the phase value that becomes current at this edge,
          // so the registered output and the phase register stay aligned.
          led_n = lat_color & {3{phase_n | ~lat_blink}};
        end
      end

      default: begin
        state_n = IDLE;
        grant_n = '0;
        led_n   = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      GRANT     <= '0;
      BUSY      <= 1'b0;
      led_q     <= '0;
      cnt       <= '0;
      dwell     <= '0;
      phase     <= 1'b1;
      lat_color <= '0;
      lat_blink <= 1'b0;
    end else begin
      state     <= state_n;
      GRANT     <= grant_n;
      BUSY      <= busy_n;
      led_q     <= led_n;
      cnt       <= cnt_n;
      dwell     <= dwell_n;
      phase     <= phase_n;
      lat_color <= lat_color_n;
      lat_blink <= lat_blink_n;
    end
  end

  assign LED_RED   = led_q[2];
  assign LED_GREEN = led_q[1];
  assign LED_BLUE  = led_q[0];

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Arbitrates the board RGB status LED between three internal requesters, such as audio status, error and heartbeat sources. It grants the LED by fixed priority and holds each grant for a minimum dwell measured in prescaled ticks. It drives the LED with the granted colour, steady or blinking. The block sits between the status logic and the top-level LED_RED/LED_GREEN/LED_BLUE pins.

## Interface
- CLKDIV, 5: SYSCLK cycles per tick; legal range ≥1.
- DWELL, 4: minimum hold per grant, in ticks; legal range ≥1.
- SYSCLK  in  1  system clock, all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  3  per-source request level; bit 0 is the highest priority.
- COLOR0, COLOR1, COLOR2  in  3 each  source colour {R,G,B}, sampled at grant.
- BLINK  in  3  per-source blink enable, sampled at grant.
- GRANT  out  3  one-hot owner; 0 when no source owns the LED.
- BUSY  out  1  high in HOLD and GAP.
- LED_RED, LED_GREEN, LED_BLUE  out  1 each  active-high LED drive, registered.

## Operation
- Reset values:
  - State = IDLE.
  - GRANT = 0, BUSY = 0, all LED outputs = 0.
  - Prescaler = 0, dwell counter = 0, blink phase = 1.
  - Latched colour and latched blink = 0.
- Assertion of RESET forces these values immediately, including mid-grant; there is no partial completion.
- Prescaler:
  - Counts 0..CLKDIV-1 while in HOLD; tick = (count == CLKDIV-1).
  - Cleared to 0 on every grant edge.
  - Width is $clog2(CLKDIV) with a minimum of 1.
- Dwell counter:
  - Loaded with DWELL on grant.
  - Decremented on each tick while nonzero; saturates at 0.
- Blink phase:
  - Set to 1 on grant; toggles on every tick.
- Arbitration: winner = lowest-index asserted REQ bit.
- IDLE:
  - LEDs 0, GRANT 0.
  - If REQ != 0 → HOLD with the winner: GRANT = onehot(winner); latch COLOR/BLINK of the winner; load dwell; clear prescaler.
- HOLD:
  - LED = latched colour & {3{phase | ~latched_blink}}.
  - COLOR/BLINK changes are ignored until the next grant.
  - While dwell != 0, stay in HOLD regardless of REQ; there is no preemption before dwell expiry.
  - When dwell == 0:
    - If the granted REQ is low, or a higher-priority REQ is high → GAP.
    - Otherwise stay in HOLD. A still-asserted owner keeps the LED indefinitely against lower-priority sources. The prescaler and blink keep running.
- GAP (exactly one cycle):
  - LEDs 0, GRANT 0, BUSY 1.
  - Re-arbitrate: if REQ != 0 → HOLD with the new winner (grant actions as in IDLE); else → IDLE.
  - The previous owner may win again if it re-asserted and is the highest pending.
- Simultaneous events:
  - REQ asserting on the same edge that dwell reaches 0 is evaluated on the following cycle.
  - A requester that pulses REQ only while another holds the LED, and drops it before the GAP, is never granted; requests are levels and are not queued.

## Timing
- IDLE request at edge N → GRANT/LEDs valid after edge N+1; latency is 1 cycle.
- With grant at edge E:
  - Ticks decrement dwell at edges E+CLKDIV·k.
  - Dwell reaches 0 at edge E+DWELL·CLKDIV.
  - Earliest GAP is at edge E+DWELL·CLKDIV+1.
  - Next grant is at edge E+DWELL·CLKDIV+2.
- Minimum GRANT high time is DWELL·CLKDIV+1 cycles.
- Blink: CLKDIV cycles on, then CLKDIV off, repeating; the first on-phase starts at the grant edge.
- All outputs are registered; there is no combinational path from REQ, COLOR or BLINK to any output.

## Test plan
All scenarios use CLKDIV=5, DWELL=4 unless noted.

- **Reset:**
  - Stimulus: assert RESET between clock edges during HOLD.
  - Required: GRANT=0, BUSY=0, all LEDs 0 with no clock edge; after release with REQ=0, the block stays in IDLE.
- **Single request:**
  - Stimulus: REQ=001, COLOR0=101, BLINK=0 at edge 10, REQ dropped at edge 12.
  - Required: GRANT=001, RED=1, GREEN=0, BLUE=1 from edge 11 through edge 31; all 0 from edge 32; BUSY falls at edge 33.
- **Priority:**
  - Stimulus: REQ=110 applied together.
  - Required: GRANT=010; COLOR1 shown; source 2 is granted only after source 1 releases and its dwell expires.
- **No early preemption:**
  - Stimulus: grant to source 2 at edge E; REQ[0] rises at E+3.
  - Required: source 2 keeps the LED until E+20; GAP at E+21; GRANT=001 at E+22.
- **Blink:**
  - Stimulus: BLINK[1]=1, COLOR1=010, REQ[1] held.
  - Required: GREEN high for 5 cycles, low for 5, repeating; COLOR1 changed mid-grant has no effect.
- **CLKDIV=1, DWELL=1:**
  - Stimulus: request then release.
  - Required: GRANT lasts 2 cycles, 1 GAP cycle, and blink toggles every cycle.
